// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: operation codes, result classes,
// divider FSM states and a magnitude helper used by the divider.
package ex_stage_pkg;

    localparam int REG_W          = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int ALUOP_W        = 8;
    localparam int ALUSEL_W       = 3;
    localparam int DIV_CYCLES_DEF = 32;

    // Decoded operation codes (aluop_i).
    typedef enum logic [ALUOP_W-1:0] {
        EXE_NOP_OP   = 8'h00,
        EXE_SRL_OP   = 8'h02,
        EXE_SRA_OP   = 8'h03,
        EXE_MOVZ_OP  = 8'h0A,
        EXE_MOVN_OP  = 8'h0B,
        EXE_MOV_OP   = 8'h0C,
        EXE_MULT_OP  = 8'h18,
        EXE_MULTU_OP = 8'h19,
        EXE_DIV_OP   = 8'h1A,
        EXE_ADD_OP   = 8'h20,
        EXE_SUB_OP   = 8'h22,
        EXE_AND_OP   = 8'h24,
        EXE_OR_OP    = 8'h25,
        EXE_XOR_OP   = 8'h26,
        EXE_NOT_OP   = 8'h28,
        EXE_SLL_OP   = 8'h7C
    } aluop_e;

    // Result classes (alusel_i). MUL is shared by MULT/MULTU/DIV.
    typedef enum logic [ALUSEL_W-1:0] {
        EXE_RES_NOP   = 3'd0,
        EXE_RES_LOGIC = 3'd1,
        EXE_RES_SHIFT = 3'd2,
        EXE_RES_MOVE  = 3'd3,
        EXE_RES_ARITH = 3'd4,
        EXE_RES_MUL   = 3'd5
    } alusel_e;

    // Divider sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_ZERO = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Absolute value when treated as signed; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [REG_W-1:0] mag32(input logic [REG_W-1:0] v,
                                               input logic             use_sign);
        return (use_sign && v[REG_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider. Works on operand magnitudes and
// applies the quotient/remainder signs when the result is presented.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);

    localparam int               CNT_W     = $clog2(DIV_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quot_q, quot_d;    // dividend shifts out as quotient shifts in
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      dvsr_q, dvsr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;

    logic [32:0]      rem_shift;
    logic [32:0]      rem_trial;
    logic [31:0]      quot_fix;
    logic [31:0]      rem_fix;

    // Next-state, datapath step and status outputs of the division sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        ready      = 1'b0;
        busy       = 1'b0;
        rem_shift  = {rem_q, quot_q[31]};
        rem_trial  = rem_shift - {1'b0, dvsr_q};

        if (annul) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d    = (opdata2 == 32'd0) ? DIV_ZERO : DIV_RUN;
                        quot_d     = mag32(opdata1, signed_div);
                        dvsr_d     = mag32(opdata2, signed_div);
                        rem_d      = 32'd0;
                        quot_neg_d = signed_div & (opdata1[31] ^ opdata2[31]);
                        rem_neg_d  = signed_div & opdata1[31];
                        cnt_d      = '0;
                    end
                end
                DIV_RUN: begin
                    busy  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (rem_shift >= {1'b0, dvsr_q}) begin
                        rem_d  = rem_trial[31:0];
                        quot_d = {quot_q[30:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift[31:0];
                        quot_d = {quot_q[30:0], 1'b0};
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_ZERO: begin
                    // Divide by zero: all-ones quotient (never sign-corrected),
                    // remainder is the dividend with its own sign restored.
                    busy       = 1'b1;
                    rem_d      = quot_q;
                    quot_d     = 32'hFFFF_FFFF;
                    quot_neg_d = 1'b0;
                    state_d    = DIV_DONE;
                end
                DIV_DONE: begin
                    // Always back to IDLE so a held DIV is not re-run from here.
                    ready   = 1'b1;
                    state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        quot_fix = quot_neg_q ? (~quot_q + 32'd1) : quot_q;
        rem_fix  = rem_neg_q  ? (~rem_q  + 32'd1) : rem_q;
        result   = {rem_fix, quot_fix};
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values sampled at this edge.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift/move/add-sub/multiply datapath,
// result-class mux, and stall generation around the iterative divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  whilo_o,
    output logic                  ov_o,
    output logic                  stallreq_o
);

    logic [31:0] logic_res, shift_res, move_res, arith_res;
    logic [31:0] sum, diff;
    logic        ov;
    logic        writes_reg;
    logic        is_mul, mul_signed, is_div;
    logic [63:0] mul_op1, mul_op2, product;
    logic        div_start, div_ready, div_busy;
    logic [63:0] div_result;

    assign sum  = reg1_i + reg2_i;
    assign diff = reg1_i - reg2_i;

    // Per-class results and operation flags decoded from aluop.
    always_comb begin
        logic_res  = 32'd0;
        shift_res  = 32'd0;
        move_res   = 32'd0;
        arith_res  = 32'd0;
        ov         = 1'b0;
        writes_reg = 1'b0;
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        is_div     = 1'b0;
        case (aluop_i)
            EXE_OR_OP:   begin logic_res = reg1_i | reg2_i; writes_reg = 1'b1; end
            EXE_AND_OP:  begin logic_res = reg1_i & reg2_i; writes_reg = 1'b1; end
            EXE_XOR_OP:  begin logic_res = reg1_i ^ reg2_i; writes_reg = 1'b1; end
            EXE_NOT_OP:  begin logic_res = ~reg1_i;         writes_reg = 1'b1; end
            EXE_SLL_OP:  begin shift_res = reg1_i << reg2_i[4:0]; writes_reg = 1'b1; end
            EXE_SRL_OP:  begin shift_res = reg1_i >> reg2_i[4:0]; writes_reg = 1'b1; end
            EXE_SRA_OP:  begin
                shift_res  = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
                writes_reg = 1'b1;
            end
            EXE_MOV_OP:  begin move_res = reg1_i; writes_reg = 1'b1; end
            EXE_MOVZ_OP,
            EXE_MOVN_OP: begin move_res = reg2_i; writes_reg = 1'b1; end
            EXE_ADD_OP:  begin
                arith_res  = sum;
                ov         = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
                writes_reg = 1'b1;
            end
            EXE_SUB_OP:  begin
                arith_res  = diff;
                ov         = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
                writes_reg = 1'b1;
            end
            EXE_MULT_OP:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            EXE_MULTU_OP: is_mul = 1'b1;
            EXE_DIV_OP:   is_div = 1'b1;
            default: ;
        endcase
    end

    // One 64-bit multiplier; signed MULT sign-extends, MULTU zero-extends.
    always_comb begin
        mul_op1 = {{32{mul_signed & reg1_i[31]}}, reg1_i};
        mul_op2 = {{32{mul_signed & reg2_i[31]}}, reg2_i};
        product = mul_op1 * mul_op2;
    end

    assign div_start = is_div & ~flush_i;

    ex_div #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_div (1'b1),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .annul      (flush_i),
        .result     (div_result),
        .ready      (div_ready),
        .busy       (div_busy)
    );

    // Output mux, HI/LO write and stall request; everything is held at zero
    // while reset is asserted.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        hi_o       = 32'd0;
        lo_o       = 32'd0;
        whilo_o    = 1'b0;
        ov_o       = 1'b0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o   = wd_i;
            wreg_o = writes_reg & wreg_i;
            ov_o   = ov;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                EXE_RES_ARITH: wdata_o = arith_res;
                default:       wdata_o = 32'd0;
            endcase
            if (is_mul) begin
                whilo_o = 1'b1;
                hi_o    = product[63:32];
                lo_o    = product[31:0];
            end else if (is_div && div_ready) begin
                whilo_o = 1'b1;
                hi_o    = div_result[63:32];
                lo_o    = div_result[31:0];
            end
            // IDLE with a DIV pending stalls in the same cycle; RUN/ZERO keep it.
            stallreq_o = div_busy | (div_start & ~div_ready);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected outputs are queued when stimulus
// is applied and popped when the DUT output is sampled on the falling edge.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, ov_o, stallreq_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] wdata;
        logic        wreg;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        ov;
        logic        stall;
        logic [4:0]  wd;
    } obs_t;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        wr;
    } stim_t;

    obs_t exp_q[$];

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .ov_o       (ov_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [31:0] wdata, input logic wreg,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic whilo, input logic ov,
                                input logic stall, input logic [4:0] wd);
        obs_t r;
        r.wdata = wdata; r.wreg = wreg; r.hi = hi; r.lo = lo;
        r.whilo = whilo; r.ov = ov; r.stall = stall; r.wd = wd;
        return r;
    endfunction

    function automatic obs_t sample();
        return mk(wdata_o, wreg_o, hi_o, lo_o, whilo_o, ov_o, stallreq_o, wd_o);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("wdata=%h wreg=%b hi=%h lo=%h whilo=%b ov=%b stall=%b wd=%0d",
                         o.wdata, o.wreg, o.hi, o.lo, o.whilo, o.ov, o.stall, o.wd);
    endfunction

    task automatic set_in(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [4:0] wd, input logic wr);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b0;
        flush_i = 1'b0;
        set_in(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 5'd9, 1'b1);
        #1;
        o = sample();
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %s, want all zero", fmt(o));
        end
        total++;
        if (dut.u_div.state_q !== DIV_IDLE) begin
            bad++;
            $display("FAIL reset_div_state: got %0d want %0d", dut.u_div.state_q, DIV_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_logic_shift();
        stim_t st[11];
        obs_t  ex[11];
        st[0]  = '{EXE_OR_OP,   EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0F0F_1234, 1'b1};
        ex[0]  = mk(32'hFFFF_1234, 1, 0, 0, 0, 0, 0, 0);
        st[1]  = '{EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1};
        ex[1]  = mk(32'h0F00_0F00, 1, 0, 0, 0, 0, 0, 0);
        st[2]  = '{EXE_XOR_OP,  EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1};
        ex[2]  = mk(32'h5555_5555, 1, 0, 0, 0, 0, 0, 0);
        st[3]  = '{EXE_NOT_OP,  EXE_RES_LOGIC, 32'h1234_5678, 32'h0,         1'b1};
        ex[3]  = mk(32'hEDCB_A987, 1, 0, 0, 0, 0, 0, 0);
        st[4]  = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0001, 32'd31,        1'b1};
        ex[4]  = mk(32'h8000_0000, 1, 0, 0, 0, 0, 0, 0);
        st[5]  = '{EXE_SRL_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'd4,         1'b1};
        ex[5]  = mk(32'h0800_0000, 1, 0, 0, 0, 0, 0, 0);
        st[6]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'd4,         1'b1};
        ex[6]  = mk(32'hF800_0000, 1, 0, 0, 0, 0, 0, 0);
        st[7]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h8000_0000, 32'd31,        1'b1};
        ex[7]  = mk(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0);
        st[8]  = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'hDEAD_BEEF, 32'd32,        1'b1};
        ex[8]  = mk(32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0);
        st[9]  = '{EXE_MOVZ_OP, EXE_RES_MOVE,  32'hCAFE_F00D, 32'h1111_2222, 1'b1};
        ex[9]  = mk(32'h1111_2222, 1, 0, 0, 0, 0, 0, 0);
        st[10] = '{EXE_MOVN_OP, EXE_RES_MOVE,  32'hCAFE_F00D, 32'h3333_4444, 1'b0};
        ex[10] = mk(32'h3333_4444, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            obs_t e, o;
            @(posedge clk); #1;
            set_in(st[i].op, st[i].sel, st[i].r1, st[i].r2, 5'(i + 1), st[i].wr);
            e = ex[i];
            e.wd = 5'(i + 1);
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL logic_shift[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_arith();
        stim_t st[6];
        obs_t  ex[6];
        st[0] = '{EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
        ex[0] = mk(32'h8000_0000, 1, 0, 0, 0, 1, 0, 0);
        st[1] = '{EXE_ADD_OP, EXE_RES_ARITH, 32'h0000_1000, 32'h0000_0234, 1'b1};
        ex[1] = mk(32'h0000_1234, 1, 0, 0, 0, 0, 0, 0);
        st[2] = '{EXE_ADD_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h8000_0000, 1'b1};
        ex[2] = mk(32'h0000_0000, 1, 0, 0, 0, 1, 0, 0);
        st[3] = '{EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h0000_0001, 1'b1};
        ex[3] = mk(32'h7FFF_FFFF, 1, 0, 0, 0, 1, 0, 0);
        st[4] = '{EXE_SUB_OP, EXE_RES_ARITH, 32'h0000_0005, 32'h0000_0007, 1'b1};
        ex[4] = mk(32'hFFFF_FFFE, 1, 0, 0, 0, 0, 0, 0);
        st[5] = '{EXE_MOV_OP, EXE_RES_MOVE,  32'hCAFE_F00D, 32'h0,         1'b1};
        ex[5] = mk(32'hCAFE_F00D, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            obs_t e, o;
            @(posedge clk); #1;
            set_in(st[i].op, st[i].sel, st[i].r1, st[i].r2, 5'(20 + i), st[i].wr);
            e = ex[i];
            e.wd = 5'(20 + i);
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL arith[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_mul_nop();
        stim_t st[5];
        obs_t  ex[5];
        st[0] = '{EXE_MULT_OP,  EXE_RES_MUL,   32'hFFFF_FFFE, 32'h0000_0003, 1'b1};
        ex[0] = mk(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1, 0, 0, 0);
        st[1] = '{EXE_MULTU_OP, EXE_RES_MUL,   32'hFFFF_FFFE, 32'h0000_0003, 1'b1};
        ex[1] = mk(0, 0, 32'h0000_0002, 32'hFFFF_FFFA, 1, 0, 0, 0);
        st[2] = '{EXE_MULT_OP,  EXE_RES_MUL,   32'h8000_0000, 32'h8000_0000, 1'b1};
        ex[2] = mk(0, 0, 32'h4000_0000, 32'h0000_0000, 1, 0, 0, 0);
        st[3] = '{EXE_NOP_OP,   EXE_RES_NOP,   32'h1234_5678, 32'h9ABC_DEF0, 1'b1};
        ex[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        st[4] = '{8'hFF,        EXE_RES_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1};
        ex[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            obs_t e, o;
            @(posedge clk); #1;
            set_in(st[i].op, st[i].sel, st[i].r1, st[i].r2, 5'd7, st[i].wr);
            e = ex[i];
            e.wd = 5'd7;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            o = sample();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mul_nop[%0d]: got %s, want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    // Two divisions issued back to back with nonzero divisors.
    task automatic test_back_to_back();
        logic [31:0] dvd[2] = '{32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] dvs[2] = '{32'h0000_0002, 32'hFFFF_FFFF};
        logic [31:0] qhi[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] qlo[2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            obs_t e;
            int   stalls;
            @(posedge clk); #1;
            set_in(EXE_DIV_OP, EXE_RES_MUL, dvd[k], dvs[k], 5'd3, 1'b1);
            exp_q.push_back(mk(0, 0, qhi[k], qlo[k], 1, 0, 0, 5'd3));
            stalls = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (whilo_o) break;
                if (!stallreq_o) break;
                stalls++;
            end
            o = sample();
            e = exp_q.pop_front();
            total++;
            if (stalls != 33) begin
                bad++;
                $display("FAIL div_stall[%0d]: got %0d cycles, want 33", k, stalls);
            end
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL div_result[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
        end
        @(posedge clk); #1;
        set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        total++;
        if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL div_single_pulse: got whilo=%b stall=%b, want 0 0", whilo_o, stallreq_o);
        end
    endtask

    // Divide by zero: short two-cycle stall, all-ones quotient.
    task automatic test_div_zero();
        logic [31:0] dvd[2] = '{32'h0000_0005, 32'hFFFF_FFFB};
        logic [31:0] qhi[2] = '{32'h0000_0005, 32'hFFFF_FFFB};
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            obs_t e;
            int   stalls;
            @(posedge clk); #1;
            set_in(EXE_DIV_OP, EXE_RES_MUL, dvd[k], 32'h0, 5'd4, 1'b0);
            exp_q.push_back(mk(0, 0, qhi[k], 32'hFFFF_FFFF, 1, 0, 0, 5'd4));
            stalls = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (whilo_o) break;
                if (!stallreq_o) break;
                stalls++;
            end
            o = sample();
            e = exp_q.pop_front();
            total++;
            if (stalls != 2) begin
                bad++;
                $display("FAIL divzero_stall[%0d]: got %0d cycles, want 2", k, stalls);
            end
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL divzero_result[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
        end
        @(posedge clk); #1;
        set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_flush();
        obs_t e, o;
        int   stalls;
        int   pulses;
        @(posedge clk); #1;
        set_in(EXE_DIV_OP, EXE_RES_MUL, 32'd100, 32'd7, 5'd5, 1'b0);
        stalls = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (stallreq_o && !whilo_o) stalls++;
        end
        total++;
        if (stalls != 9) begin
            bad++;
            $display("FAIL flush_prestall: got %0d, want 9", stalls);
        end
        @(posedge clk); #1;
        flush_i = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'd5));
        @(negedge clk);
        e = exp_q.pop_front();
        o = sample();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL flush_cycle: got %s, want %s", fmt(o), fmt(e));
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        total++;
        if (dut.u_div.state_q !== DIV_IDLE) begin
            bad++;
            $display("FAIL flush_state: got %0d want %0d", dut.u_div.state_q, DIV_IDLE);
        end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o || stallreq_o) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL flush_no_result: got %0d whilo/stall cycles, want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_div();
        obs_t o;
        int   pulses;
        @(posedge clk); #1;
        set_in(EXE_DIV_OP, EXE_RES_MUL, 32'd100, 32'd7, 5'd6, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        o = sample();
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_mid_div_outputs: got %s, want all zero", fmt(o));
        end
        total++;
        if (dut.u_div.state_q !== DIV_IDLE) begin
            bad++;
            $display("FAIL reset_mid_div_state: got %0d want %0d", dut.u_div.state_q, DIV_IDLE);
        end
        @(posedge clk); #1;
        set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_div_no_result: got %0d whilo cycles, want 0", pulses);
        end
    endtask

    initial begin
        flush_i = 1'b0;
        test_reset();
        test_logic_shift();
        test_arith();
        test_mul_nop();
        test_back_to_back();
        test_div_zero();
        test_flush();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage. Sits directly downstream of instruction decode, behind the ID/EX pipeline register.
- Consumes decoded aluop/alusel, two 32-bit operands, destination address and write enable.
- Produces the writeback result, which also drives the ex_* forwarding bus back to decode.
- Single-cycle ALU, shift, move, add/sub and multiply ops complete combinationally; signed DIV runs on an iterative radix-2 divider that stalls the pipeline.

Parameters:
- DIV_CYCLES, 32, number of restoring-division iterations (equals operand width).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  abort the in-flight instruction, including a running division
- aluop_i  in  `AluOpBus  decoded operation
- alusel_i  in  `AluSelBus  result-class select
- reg1_i  in  `RegBus  operand 1 (register or immediate)
- reg2_i  in  `RegBus  operand 2 (register or immediate)
- wd_i  in  `RegAddrBus  destination register
- wreg_i  in  1  destination write enable from decode
- wd_o  out  `RegAddrBus  destination register, passthrough
- wreg_o  out  1  register write enable
- wdata_o  out  `RegBus  result; also the ex forwarding data
- hi_o  out  `RegBus  high result word of MULT/MULTU/DIV
- lo_o  out  `RegBus  low result word of MULT/MULTU/DIV
- whilo_o  out  1  HI/LO write strobe
- ov_o  out  1  signed overflow flag for ADD/SUB (informational, no trap)
- stallreq_o  out  1  request to freeze PC/IF/ID/ID-EX

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- While rst=0, every output is 0 and the divider FSM is held in IDLE.
- All non-DIV results are combinational from the inputs; latency is 0 cycles to the outputs.

Operation results:
- OR, AND, XOR: bitwise on reg1_i, reg2_i.
- NOT: ~reg1_i.
- SHL: reg1_i << reg2_i[4:0].
- SHR: logical right shift.
- SAR: arithmetic right shift. Shift amounts 0-31 only.
- MOV: wdata_o = reg1_i. MOVZ/MOVN: wdata_o = reg2_i; wreg_o = wreg_i (decode already resolved the condition).
- ADD/SUB: 32-bit wraparound. ov_o = signed overflow; the result is still written.
- MULT (signed) and MULTU: 64-bit product, hi_o = [63:32], lo_o = [31:0], whilo_o = 1, wreg_o = 0, single cycle.
- DIV: signed. lo_o = quotient truncated toward zero, hi_o = remainder with the dividend's sign, wreg_o = 0.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Unknown aluop or NOP: wdata_o = 0, wreg_o = 0, whilo_o = 0.

Divider FSM (states IDLE, RUN, ZERO, DONE):
- IDLE: on DIV, stallreq_o = 1 combinationally in the same cycle.
  - Next state is ZERO if reg2_i == 0, otherwise RUN.
  - On entry, latch the operand magnitudes, the quotient sign and the remainder sign; clear the counter.
- RUN: one shift-subtract per cycle; the counter increments. After DIV_CYCLES iterations, go to DONE. stallreq_o = 1.
- ZERO: load quotient = 0xFFFFFFFF, remainder = dividend; go to DONE. stallreq_o = 1.
- DONE: present the sign-corrected result.
  - whilo_o = 1, stallreq_o = 0.
  - The next state is IDLE unconditionally, so an identical DIV held on the inputs is not restarted.
- Timing:
  - Nonzero divisor: stall asserted for 33 cycles (IDLE cycle plus 32 RUN cycles); result presented in the 34th cycle.
  - Zero divisor: stall for 2 cycles; result in the 3rd cycle.
- whilo_o is 0 during IDLE/RUN/ZERO for DIV.
- flush_i=1 in any state: FSM goes to IDLE at the next edge; stallreq_o = 0 and whilo_o = 0 in that cycle.
- Reset mid-division: asynchronous return to IDLE; no result is emitted.
- Inputs must stay stable while stallreq_o = 1 (guaranteed upstream). The FSM samples the operands only on the IDLE→RUN/ZERO edge.

Decomposition:
- Add to defines.v: DivIdle/DivRun/DivZero/DivDone state codes, DIV_CYCLES default, and any missing EXE_*_OP / EXE_RES_* codes (EXE_RES_MUL is reused for the DIV result class).
- One sub-module: ex_div.
  - Inputs: clk, rst, start, signed_div, opdata1, opdata2, annul.
  - Outputs: result[63:0], ready, busy.
- ex_stage holds the combinational datapath, the result-class mux and stall generation.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, wreg_i = 1 → wdata_o = 0x80000000, ov_o = 1, wreg_o = 1, stallreq_o = 0.
- SAR reg1 = 0x80000000, reg2 = 4 → wdata_o = 0xF8000000. SHR with the same operands → 0x08000000.
- MULT 0xFFFFFFFE × 0x00000003 → hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFA, whilo_o = 1, wreg_o = 0. MULTU with the same operands → hi_o = 0x00000002, lo_o = 0xFFFFFFFA.
- DIV -7 / 2 held stable → stallreq_o high 33 cycles; in cycle 34 lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, whilo_o = 1 for exactly one cycle; back-to-back DIV starts fresh.
- DIV 5 / 0 → stall 2 cycles, then lo_o = 0xFFFFFFFF, hi_o = 0x00000005.
- DIV in progress, flush_i pulse at cycle 10 → stallreq_o = 0 that cycle, no whilo_o pulse. Then assert rst low during a later DIV → all outputs 0 immediately, FSM in IDLE.
